// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the PC next-index sequencer.
package pc_seq_pkg;

  localparam int unsigned PC_W       = 32;
  localparam int unsigned FLUSH_CNT_W = 4;

  localparam logic [PC_W-1:0] PC_RESET_VEC = 32'h0000_0000;
  localparam logic [PC_W-1:0] PC_EXC_VEC   = 32'h0000_0080;

  // Sequencer control states
  typedef enum logic [1:0] {
    BOOT      = 2'd0,
    RUN       = 2'd1,
    EXC_FLUSH = 2'd2
  } pc_seq_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between control/hazard logic, the PC register and the sequencer.
//   master: drives pc_cur, stall, branch/jump/exception requests; observes results
//   slave : the sequencer, produces pc_next, flush, epc, busy
interface pc_sequencer_if #(
  parameter int unsigned SIZE = 32
);
  logic [SIZE-1:0] pc_cur;
  logic            stall;
  logic            br_taken;
  logic [SIZE-1:0] br_target;
  logic            jmp_valid;
  logic [SIZE-1:0] jmp_target;
  logic            exc_valid;
  logic [SIZE-1:0] pc_next;
  logic            flush;
  logic [SIZE-1:0] epc;
  logic            busy;

  modport master (
    output pc_cur, stall, br_taken, br_target, jmp_valid, jmp_target, exc_valid,
    input  pc_next, flush, epc, busy
  );

  modport slave (
    input  pc_cur, stall, br_taken, br_target, jmp_valid, jmp_target, exc_valid,
    output pc_next, flush, epc, busy
  );
endinterface

// File: rtl/pc_redirect_mux.sv
// Combinational priority select of the next PC index.
//   in : state, pc_cur, stall, pending redirect, branch/jump/exception requests
//   out: pc_next_c
module pc_redirect_mux
  import pc_seq_pkg::*;
#(
  parameter int unsigned     SIZE      = 32,
  parameter logic [SIZE-1:0] RESET_VEC = SIZE'(PC_RESET_VEC),
  parameter logic [SIZE-1:0] EXC_VEC   = SIZE'(PC_EXC_VEC)
) (
  input  pc_seq_state_e   state,
  input  logic [SIZE-1:0] pc_cur,
  input  logic            stall,
  input  logic            pending_valid,
  input  logic [SIZE-1:0] pending_addr,
  input  logic            br_taken,
  input  logic [SIZE-1:0] br_target,
  input  logic            jmp_valid,
  input  logic [SIZE-1:0] jmp_target,
  input  logic            exc_valid,
  output logic [SIZE-1:0] pc_next_c
);

  logic [SIZE-1:0] pc_seq;

  assign pc_seq = pc_cur + SIZE'(4);

  // Exception > stall > parked redirect > jump > branch > sequential
  always_comb begin
    pc_next_c = RESET_VEC;
    case (state)
      BOOT: pc_next_c = RESET_VEC;
      RUN: begin
        if (exc_valid)          pc_next_c = EXC_VEC;
        else if (stall)         pc_next_c = pc_cur;
        else if (pending_valid) pc_next_c = pending_addr;
        else if (jmp_valid)     pc_next_c = jmp_target;
        else if (br_taken)      pc_next_c = br_target;
        else                    pc_next_c = pc_seq;
      end
      EXC_FLUSH: begin
        if (exc_valid)  pc_next_c = EXC_VEC;
        else if (stall) pc_next_c = pc_cur;
        else            pc_next_c = pc_seq;
      end
      default: pc_next_c = RESET_VEC;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-index controller for the PC register: boot sequencing, redirect
// arbitration, stall hold with parked redirect, exception flush and epc capture.
//   clk, rst (async, active-low)
//   bus.slave: pc_cur/stall/br/jmp/exc in; pc_next/flush/epc/busy out
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned     SIZE         = 32,
  parameter logic [SIZE-1:0] RESET_VEC    = SIZE'(PC_RESET_VEC),
  parameter logic [SIZE-1:0] EXC_VEC      = SIZE'(PC_EXC_VEC),
  parameter int unsigned     FLUSH_CYCLES = 3
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.slave  bus
);

  localparam int unsigned CNT_W = FLUSH_CNT_W;

  pc_seq_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            pend_valid_q, pend_valid_d;
  logic [SIZE-1:0] pend_addr_q, pend_addr_d;
  logic [SIZE-1:0] epc_q, epc_d;
  logic            flush_q, flush_d;
  logic            busy_q, busy_d;
  logic [SIZE-1:0] pc_next_c;

  pc_redirect_mux #(
    .SIZE      (SIZE),
    .RESET_VEC (RESET_VEC),
    .EXC_VEC   (EXC_VEC)
  ) u_mux (
    .state         (state_q),
    .pc_cur        (bus.pc_cur),
    .stall         (bus.stall),
    .pending_valid (pend_valid_q),
    .pending_addr  (pend_addr_q),
    .br_taken      (bus.br_taken),
    .br_target     (bus.br_target),
    .jmp_valid     (bus.jmp_valid),
    .jmp_target    (bus.jmp_target),
    .exc_valid     (bus.exc_valid),
    .pc_next_c     (pc_next_c)
  );

  // State register and sequencing storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= BOOT;
      cnt_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      epc_q        <= '0;
      flush_q      <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      epc_q        <= epc_d;
      flush_q      <= flush_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state, flush counter, parked redirect and epc capture
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    epc_d        = epc_q;

    case (state_q)
      BOOT: state_d = RUN;

      RUN: begin
        if (bus.exc_valid) begin
          epc_d        = bus.pc_cur;
          cnt_d        = CNT_W'(FLUSH_CYCLES);
          pend_valid_d = 1'b0;
          pend_addr_d  = '0;
          state_d      = EXC_FLUSH;
        end else if (bus.stall) begin
          // Newest redirect wins; jump beats branch within a cycle
          if (bus.jmp_valid) begin
            pend_valid_d = 1'b1;
            pend_addr_d  = bus.jmp_target;
          end else if (bus.br_taken) begin
            pend_valid_d = 1'b1;
            pend_addr_d  = bus.br_target;
          end
        end else if (pend_valid_q) begin
          pend_valid_d = 1'b0;
        end
      end

      EXC_FLUSH: begin
        if (bus.exc_valid) begin
          epc_d = bus.pc_cur;
          cnt_d = CNT_W'(FLUSH_CYCLES);
        end else if (!bus.stall) begin
          if (cnt_q <= CNT_W'(1)) state_d = RUN;
          else                    cnt_d   = cnt_q - CNT_W'(1);
        end
      end

      default: state_d = BOOT;
    endcase
  end

  // Status outputs follow the upcoming state so they are registered
  always_comb begin
    flush_d = (state_d == EXC_FLUSH);
    busy_d  = (state_d != RUN);
  end

  assign bus.pc_next = pc_next_c;
  assign bus.flush   = flush_q;
  assign bus.busy    = busy_q;
  assign bus.epc     = epc_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-index controller for the 32-bit PC register. It arbitrates the sequential, branch, jump and exception redirect sources into one `pc_next` value, which drives the PC register's `index_in`.
- Holds the PC during pipeline stalls and parks any redirect that arrives while stalled.
- Sequences boot and exception-flush windows and captures the exception return address (`epc`).
- Sits between the control unit / hazard unit and the PC register.

Parameters:
- SIZE, 32, width of the instruction index / address.
- RESET_VEC, 32'h0000_0000, first fetch index after reset.
- EXC_VEC, 32'h0000_0080, exception handler entry index.
- FLUSH_CYCLES, 3, number of cycles `flush` stays asserted after an exception is taken (1..15).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- pc_cur  in  SIZE  current PC register output (`index_out`).
- stall  in  1  hazard unit request to hold the PC.
- br_taken  in  1  resolved taken-branch redirect request.
- br_target  in  SIZE  branch target index.
- jmp_valid  in  1  jump/jr redirect request.
- jmp_target  in  SIZE  jump target index.
- exc_valid  in  1  exception request (overflow, illegal op, ...).
- pc_next  out  SIZE  value to load into the PC register this cycle.
- flush  out  1  squash younger pipeline stages.
- epc  out  SIZE  index of the faulting instruction.
- busy  out  1  high in BOOT or EXC_FLUSH.

Behaviour:
- States: BOOT, RUN, EXC_FLUSH. Encoding lives in the package.
- Reset (`rst`=0, asynchronous):
  - state=BOOT, flush counter=0, pending_valid=0, pending_addr=0, epc=0.
  - Outputs during reset: `flush`=0, `busy`=1, `pc_next`=RESET_VEC.
- BOOT:
  - `pc_next`=RESET_VEC, `flush`=0.
  - All requests are ignored.
  - Next state is RUN unconditionally after one cycle, stall or no stall.
- RUN, `pc_next` is combinational and uses this fixed priority:
  1. exc_valid: `pc_next`=EXC_VEC; on the clock edge, `epc`<=`pc_cur`, counter<=FLUSH_CYCLES, pending cleared, state<=EXC_FLUSH. Exception wins even when `stall`=1.
  2. stall: `pc_next`=`pc_cur`. If jmp_valid or br_taken is set, latch its target into pending_addr with pending_valid<=1 (jump beats branch). A later redirect overwrites the pending one.
  3. pending_valid: `pc_next`=pending_addr; pending_valid<=0 on the clock edge. Any new br/jmp in this same cycle is ignored, because the pending redirect is older.
  4. jmp_valid: `pc_next`=jmp_target.
  5. br_taken: `pc_next`=br_target.
  6. Otherwise: `pc_next`=`pc_cur`+4, modulo 2^SIZE (0xFFFF_FFFC wraps to 0).
- Redirect latency: zero cycles when not stalled. When stalled, the redirect takes effect in the first cycle with `stall`=0.
- EXC_FLUSH:
  - `flush`=1 and `busy`=1.
  - br_taken and jmp_valid are ignored.
  - `pc_next`=`pc_cur` while `stall`=1, otherwise `pc_cur`+4.
  - The counter decrements only when `stall`=0.
  - When the counter reaches 1 with `stall`=0, state<=RUN on the next edge.
  - A new exc_valid during EXC_FLUSH behaves like the RUN case: `pc_next`=EXC_VEC, `epc` recaptured, counter reloaded to FLUSH_CYCLES.
- `flush` is registered from state, so it is 0 in the cycle exc_valid is accepted and 1 from the next cycle on.
- Reset asserted mid-operation aborts everything immediately, with no partial pending redirect surviving.
- No arithmetic beyond +4; targets are passed through unmodified, with no alignment check.

Decomposition:
- Package `pc_seq_pkg`:
  - State enum/localparams (BOOT=2'd0, RUN=2'd1, EXC_FLUSH=2'd2).
  - RESET_VEC and EXC_VEC defaults.
  - Flush counter width (4).
- One natural sub-module, `pc_redirect_mux`: a purely combinational priority select of `pc_next` from the state and request inputs.
- FSM, counter, pending register and `epc` stay in the top module.

Test Plan:
- Reset/boot: hold `rst`=0 for 3 cycles, then release -> `pc_next`=0x0 and `busy`=1 in BOOT. Next cycle, with `pc_cur`=0x0, `pc_next`=0x4, `busy`=0 and `flush`=0.
- Priority: in RUN with `pc_cur`=0x100, assert br_taken (target 0x200) and jmp_valid (target 0x300) together -> `pc_next`=0x300. With br_taken alone -> `pc_next`=0x200.
- Stalled redirect: `pc_cur`=0x40, `stall`=1 for 2 cycles, br_taken with target 0x80 in the first stall cycle -> `pc_next`=0x40 in both stall cycles, then `pc_next`=0x80 in the first cycle with `stall`=0 while a simultaneous jmp to 0x500 is ignored.
- Exception: `pc_cur`=0x1C, exc_valid=1 -> `pc_next`=0x80 and `epc`=0x1C next cycle. `flush`=1 for exactly 3 non-stalled cycles, and a br_taken inside the window is ignored.
- Flush with stall and re-exception: insert 2 stall cycles mid-flush -> `flush` window extends to 5 cycles. exc_valid again in flush cycle 2 with `pc_cur`=0x84 -> `epc`=0x84 and the counter restarts at 3.
- Wrap and async reset: `pc_cur`=0xFFFF_FFFC, no requests -> `pc_next`=0x0. Drop `rst` mid-EXC_FLUSH between clock edges -> `flush`=0 and state=BOOT immediately, without waiting for a clock edge.
